// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the frame buffer read-side path.
//   - nominal 640x480@60 totals and the last linear pixel address
//   - frame buffer address / data widths and the RGB444 field positions
//   - vga_tap_t: one stage-0 timing sample carried down the latency delay line
package vga_pkg;

  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int FRAME_PIXELS = 307199;   // last linear address of a 640x480 frame

  localparam int ADDR_W = 19;
  localparam int RGB_W  = 12;

  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic first;
  } vga_tap_t;

  // Blank pixel with both syncs deasserted (high).
  localparam vga_tap_t TAP_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0};

  function automatic logic [3:0] rgb_r(input logic [RGB_W-1:0] w);
    return w[R_HI:R_LO];
  endfunction

  function automatic logic [3:0] rgb_g(input logic [RGB_W-1:0] w);
    return w[G_HI:G_LO];
  endfunction

  function automatic logic [3:0] rgb_b(input logic [RGB_W-1:0] w);
    return w[B_HI:B_LO];
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: stage-0 raster counters.
// Ports:
//   clk_read, rst_n  pixel clock, async active-low reset
//   go               scan running; when low both counters are held at 0
//   active           current position is a visible pixel
//   hs0, vs0         raw syncs, active low
//   first_px         position (0,0)
//   last_px          last visible pixel of the frame
//   frame_end        last position of the frame (h and v both at their totals-1)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk_read,
  input  logic rst_n,
  input  logic go,
  output logic active,
  output logic hs0,
  output logic vs0,
  output logic first_px,
  output logic last_px,
  output logic frame_end
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W   = $clog2(H_TOT);
  localparam int V_W   = $clog2(V_TOT);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOT - 1);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOT - 1);
  localparam logic [H_W-1:0] H_ACT      = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT      = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] H_ACT_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0] V_ACT_LAST = V_W'(V_ACTIVE - 1);
  localparam logic [H_W-1:0] HS_FIRST   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] VS_FIRST   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!go) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs0       = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign vs0       = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
  assign first_px  = (h_cnt == '0) && (v_cnt == '0);
  assign last_px   = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/frame_reader.sv
// frame_reader: frame buffer read sequencer and VGA output stage.
// Ports:
//   clk_read, rst_n        pixel clock, async active-low reset
//   enable                 run scan-out; low = idle, blank, syncs high
//   read_data              frame buffer word {R,G,B}, MEM_LATENCY cycles after read_en
//   read_en, read_addr     frame buffer read port (linear pixel address)
//   vga_hsync, vga_vsync   active-low syncs
//   vga_r/g/b, vga_de      colour (zero in blanking) and data enable
//   frame_start            one-cycle pulse with pixel (0,0) on the pins
// Requires MEM_LATENCY >= 1.
module frame_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk_read,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [RGB_W-1:0]  read_data,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_addr,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_de,
  output logic              frame_start
);

  logic run_q;
  logic go;
  logic active, hs0, vs0, first_px, last_px, frame_end;

  logic [ADDR_W-1:0] addr_q;
  vga_tap_t          tap0;
  vga_tap_t          dly_q [MEM_LATENCY+1];
  logic [RGB_W-1:0]  rgb_q;

  // run_q delays a rising enable by one edge so the counters are guaranteed
  // to sit at (0,0) before the first read; a falling enable stops reads at once.
  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= enable;
  end

  assign go = run_q && enable;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_read  (clk_read),
    .rst_n     (rst_n),
    .go        (go),
    .active    (active),
    .hs0       (hs0),
    .vs0       (vs0),
    .first_px  (first_px),
    .last_px   (last_px),
    .frame_end (frame_end)
  );

  // Linear address: steps after every visible pixel except the last one of
  // the frame, so it parks on the final address through vertical blanking.
  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (!go) begin
      addr_q <= '0;
    end else if (active && !last_px) begin
      addr_q <= addr_q + 1'b1;
    end else if (frame_end) begin
      addr_q <= '0;
    end
  end

  assign read_en   = go && active;
  assign read_addr = addr_q;

  always_comb begin
    tap0 = TAP_IDLE;
    if (go) begin
      tap0.active = active;
      tap0.hs     = hs0;
      tap0.vs     = vs0;
      tap0.first  = first_px;
    end
  end

  // dly_q[k] holds the stage-0 sample from k+1 cycles ago. read_data arriving
  // now belongs to dly_q[MEM_LATENCY-1]; the pins read dly_q[MEM_LATENCY],
  // which lines up with rgb_q one edge later.
  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= MEM_LATENCY; i++) dly_q[i] <= TAP_IDLE;
      rgb_q <= '0;
    end else begin
      dly_q[0] <= tap0;
      for (int i = 1; i <= MEM_LATENCY; i++) dly_q[i] <= dly_q[i-1];
      rgb_q <= dly_q[MEM_LATENCY-1].active ? read_data : '0;
    end
  end

  assign vga_de      = dly_q[MEM_LATENCY].active;
  assign vga_hsync   = dly_q[MEM_LATENCY].hs;
  assign vga_vsync   = dly_q[MEM_LATENCY].vs;
  assign frame_start = dly_q[MEM_LATENCY].first;
  assign vga_r       = rgb_r(rgb_q);
  assign vga_g       = rgb_g(rgb_q);
  assign vga_b       = rgb_b(rgb_q);

endmodule

// File: tb/tb_frame_reader.sv
module tb_frame_reader;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int ML = 1;
  localparam int HT = HA + HFP + HS + HBP;   // 15
  localparam int VT = VA + VFP + VS + VBP;   // 8
  localparam int FT = HT * VT;               // 120

  logic        clk_read = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] read_data = '0;
  logic        read_en;
  logic [18:0] read_addr;
  logic        vga_hsync, vga_vsync, vga_de, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;

  frame_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .MEM_LATENCY(ML)
  ) dut (
    .clk_read(clk_read), .rst_n(rst_n), .enable(enable), .read_data(read_data),
    .read_en(read_en), .read_addr(read_addr),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_de(vga_de), .frame_start(frame_start)
  );

  always #20 clk_read = ~clk_read;

  // Frame buffer stand-in: returns addr[11:0] one cycle after the read.
  always @(posedge clk_read) if (read_en) read_data <= read_addr[11:0];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk_read) cyc++;

  // Reference model: scan position is a plain index k into the frame,
  // restarted whenever scanning was not running on both sides of an edge.
  typedef struct {
    bit act;
    bit hs;
    bit vs;
    bit first;
    int addr;
  } samp_t;

  localparam samp_t IDLE = '{act: 0, hs: 1, vs: 1, first: 0, addr: 0};

  function automatic samp_t pos_of(input int k);
    samp_t s;
    int h, v;
    h = k % HT;
    v = k / HT;
    s.act   = (h < HA) && (v < VA);
    s.hs    = !(h >= HA + HFP && h < HA + HFP + HS);
    s.vs    = !(v >= VA + VFP && v < VA + VFP + VS);
    s.first = (k == 0);
    s.addr  = v * HA + h;
    return s;
  endfunction

  int mk = 0;
  bit mrun = 0;

  always @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      mk = 0;
      mrun = 0;
    end else begin
      if (mrun && enable) mk = (mk + 1) % FT;
      else                mk = 0;
      mrun = enable;
    end
  end

  samp_t h1 = IDLE, h2 = IDLE, s_cur, s_exp;

  // Monitor results used by the literal checks.
  int fs_last = -1, fs_period = 0, vs_cnt = 0, vs_frame = 0;
  int hs_cnt = 0, hs_len = 0, de_fall = -1000, hs_gap = 0;
  int re_low = 0, line_gap = 0, max_addr = 0;
  bit prev_de = 0, prev_hs = 1;

  always @(negedge clk_read) begin
    if (!rst_n) begin
      h1 = IDLE;
      h2 = IDLE;
      s_cur = IDLE;
    end else begin
      s_cur = (mrun && enable) ? pos_of(mk) : IDLE;
    end
    s_exp = h2;
    h2 = h1;
    h1 = s_cur;

    chk("read_en", read_en, s_cur.act);
    if (s_cur.act) chk("read_addr", read_addr, s_cur.addr);
    chk("vga_de", vga_de, s_exp.act);
    chk("vga_hsync", vga_hsync, s_exp.hs);
    chk("vga_vsync", vga_vsync, s_exp.vs);
    chk("frame_start", frame_start, s_exp.first);
    chk("rgb", {vga_r, vga_g, vga_b}, s_exp.act ? (s_exp.addr & 32'hfff) : 0);

    if (frame_start) begin
      if (fs_last >= 0) fs_period = cyc - fs_last;
      fs_last = cyc;
      vs_frame = vs_cnt;
      vs_cnt = 0;
    end
    if (!vga_vsync) vs_cnt++;
    if (!vga_hsync) hs_cnt++;
    else if (hs_cnt > 0) begin
      hs_len = hs_cnt;
      hs_cnt = 0;
    end
    if (prev_de && !vga_de) de_fall = cyc;
    if (prev_hs && !vga_hsync && (cyc - de_fall) < HT) hs_gap = cyc - de_fall;
    prev_de = vga_de;
    prev_hs = vga_hsync;
    if (read_en) begin
      if (read_addr == HA) line_gap = re_low;
      if (int'(read_addr) > max_addr) max_addr = int'(read_addr);
      re_low = 0;
    end else begin
      re_low++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_read);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst_n = 0;
    enable = 0;
    tick(10);
    rst_n = 1;
    tick(3);
    chk("idle read_en", read_en, 0);
    chk("idle read_addr", read_addr, 0);
    chk("idle hsync", vga_hsync, 1);
    chk("idle vsync", vga_vsync, 1);
    chk("idle de", vga_de, 0);
    chk("idle rgb", {vga_r, vga_g, vga_b}, 0);
    chk("idle frame_start", frame_start, 0);

    // Start of scan.
    enable = 1;
    #1 chk("start read_en before edge", read_en, 0);
    tick(1);
    chk("start read_en", read_en, 1);
    chk("start read_addr", read_addr, 0);
    chk("start de not yet", vga_de, 0);
    tick(2);
    chk("first de", vga_de, 1);
    chk("first frame_start", frame_start, 1);
    chk("first rgb", {vga_r, vga_g, vga_b}, 12'h000);
    tick(1);
    chk("second rgb", {vga_r, vga_g, vga_b}, 12'h001);
    chk("second frame_start", frame_start, 0);

    // Two full frames of free-running scan.
    tick(2 * FT + 20);
    chk("frame_start period", fs_period, FT);
    chk("vsync low per frame", vs_frame, VS * HT);
    chk("hsync low width", hs_len, HS);
    chk("de fall to hsync", hs_gap, HFP);
    chk("read_en line gap", line_gap, HT - HA);
    chk("last visible addr", max_addr, HA * VA - 1);

    // Mid-frame disable on line 2, pixel 5.
    found = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clk_read);
      if (read_en && read_addr == 2 * HA + 4) begin
        found = 1;
        break;
      end
    end
    chk("reach line2 pixel4", found, 1);
    @(posedge clk_read);
    #1 enable = 0;
    #1 chk("drop read_en", read_en, 0);
    chk("drain 1 de", vga_de, 1);
    chk("drain 1 rgb", {vga_r, vga_g, vga_b}, 2 * HA + 3);
    tick(1);
    chk("drain 2 de", vga_de, 1);
    chk("drain 2 rgb", {vga_r, vga_g, vga_b}, 2 * HA + 4);
    chk("cleared addr", read_addr, 0);
    tick(1);
    chk("blank de", vga_de, 0);
    chk("blank rgb", {vga_r, vga_g, vga_b}, 0);
    chk("blank hsync", vga_hsync, 1);
    chk("blank vsync", vga_vsync, 1);
    tick(5);

    // Re-enable restarts at the frame top.
    enable = 1;
    #1 chk("reen read_en before edge", read_en, 0);
    tick(1);
    chk("reen read_en", read_en, 1);
    chk("reen read_addr", read_addr, 0);
    tick(2);
    chk("reen frame_start", frame_start, 1);
    chk("reen rgb", {vga_r, vga_g, vga_b}, 0);
    tick(3);
    chk("pre-reset de", vga_de, 1);

    // Asynchronous reset between clock edges.
    #8 rst_n = 0;
    #1;
    chk("async read_en", read_en, 0);
    chk("async read_addr", read_addr, 0);
    chk("async de", vga_de, 0);
    chk("async rgb", {vga_r, vga_g, vga_b}, 0);
    chk("async hsync", vga_hsync, 1);
    tick(3);
    rst_n = 1;
    #1 chk("post-reset read_en before edge", read_en, 0);
    tick(1);
    chk("post-reset read_en", read_en, 1);
    chk("post-reset read_addr", read_addr, 0);
    tick(2);
    chk("post-reset frame_start", frame_start, 1);
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
